cache_replacement_unit: RTL

Per-set victim-selection and replacement-state unit for the set-associative caches in `mips_core`. It replaces the fixed 4-way, per-set pseudo-LRU instances with one array covering every set. Associativity is any power of two from 2 to 16, and the policy is selectable: tree-PLRU, per-set round-robin, or global LFSR random. It sits beside the tag banks, takes touch/fill events from the cache FSM, and reports a victim way for the set currently being looked up.

---
 rtl/cache_replacement_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/cache_replacement_unit.sv
// rtl/cache_replacement_unit.sv - per-set victim selection with tree-PLRU, round-robin or LFSR policy
module cache_replacement_unit #(
    parameter int DEPTH         = 32,
    parameter int ASSOCIATIVITY = 4,
    parameter int POLICY        = 0,
    localparam int IW           = $clog2(DEPTH),
    localparam int WW           = $clog2(ASSOCIATIVITY)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IW-1:0]            query_index,
    input  logic [ASSOCIATIVITY-1:0] query_valid_ways,
    output logic [WW-1:0]            victim_way,
    output logic                     all_valid,
    input  logic                     touch_en,
    input  logic [IW-1:0]            touch_index,
    input  logic [WW-1:0]            touch_way,
    input  logic                     fill_en,
    input  logic [IW-1:0]            fill_index,
    input  logic [WW-1:0]            fill_way
);
    localparam int NW = ASSOCIATIVITY - 1;

    logic [WW-1:0] policy_way;
    logic [WW-1:0] invalid_way;

    if (ASSOCIATIVITY < 2 || ASSOCIATIVITY > 16 || (ASSOCIATIVITY & (ASSOCIATIVITY - 1)) != 0) begin : g_bad_assoc
        $error("ASSOCIATIVITY must be a power of two from 2 to 16");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two, at least 2");
    end

    // Lowest-indexed invalid way wins over any policy choice.
    always_comb begin
        invalid_way = '0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if ((query_valid_ways & (ASSOCIATIVITY'(1) << w)) == '0) invalid_way = WW'(w);
        end
    end

    assign all_valid  = &query_valid_ways;
    assign victim_way = all_valid ? policy_way : invalid_way;

    if (POLICY == 0) begin : g_plru
        logic [NW-1:0] tree [DEPTH];
        logic          touch_live;

        // Nodes are heap-ordered, so level l's node on a way's path is (2^l - 1) + (way >> (WW - l)).
        function automatic logic [NW-1:0] touched(input logic [NW-1:0] row, input logic [WW-1:0] way);
            logic [NW-1:0] r;
            int            node;
            r = row;
            for (int l = 0; l < WW; l++) begin
                node = (1 << l) - 1 + int'(way >> (WW - l));
                if (((way >> (WW - 1 - l)) & WW'(1)) == '0) r = r | (NW'(1) << node);
                else                                        r = r & ~(NW'(1) << node);
            end
            return r;
        endfunction

        always_comb begin
            logic [NW-1:0] row;
            int            node;
            row  = tree[query_index];
            node = 0;
            for (int l = 0; l < WW; l++) begin
                node = 2 * node + 1 + (((row & (NW'(1) << node)) != '0) ? 1 : 0);
            end
            policy_way = WW'(node - NW);
        end

        // A fill to the same set overrides the touch.
        assign touch_live = touch_en && !(fill_en && fill_index == touch_index);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                tree <= '{default: '0};
            end else begin
                if (touch_live) tree[touch_index] <= touched(tree[touch_index], touch_way);
                if (fill_en)    tree[fill_index]  <= touched(tree[fill_index], fill_way);
            end
        end
    end else if (POLICY == 1) begin : g_rr
        logic [WW-1:0] ctr [DEPTH];
        logic          rr_unused;

        assign rr_unused  = ^{touch_en, touch_index, touch_way, fill_way};
        assign policy_way = ctr[query_index];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                ctr <= '{default: '0};
            end else if (fill_en) begin
                ctr[fill_index] <= ctr[fill_index] + 1'b1;
            end
        end
    end else if (POLICY == 2) begin : g_lfsr
        logic [15:0] lfsr;
        logic        lfsr_unused;

        assign lfsr_unused = ^{query_index, touch_en, touch_index, touch_way, fill_en, fill_index, fill_way};
        assign policy_way  = lfsr[WW-1:0];

        // x^16 + x^14 + x^13 + x^11 + 1, shifting left with feedback into bit 0.
        always_ff @(posedge clk) begin
            if (!rst_n) lfsr <= 16'hACE1;
            else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end else begin : g_bad_policy
        $error("POLICY must be 0, 1 or 2");
    end
endmodule
